data_mem_ctrl: RTL and testbench

//  Data memory with a multi-cycle load/store handshake. Sits in the MEM stage.

---
 rtl/data_mem_if.sv | 40 ++++
 rtl/data_mem_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// MEM-stage load/store bus between the pipeline and the data memory.
// The pipeline drives requests; the memory returns data and status pulses.
interface data_mem_if;
  logic        memread;
  logic        memwrite;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        misalign;

  modport master (
    output memread,
    output memwrite,
    output size,
    output unsigned_ld,
    output addr,
    output wdata,
    input  rdata,
    input  ready,
    input  busy,
    input  misalign
  );

  modport slave (
    input  memread,
    input  memwrite,
    input  size,
    input  unsigned_ld,
    input  addr,
    input  wdata,
    output rdata,
    output ready,
    output busy,
    output misalign
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory: multi-cycle byte/half/word load and store,
// little-endian, sign/zero-extended loads, misaligned-request detection.
module data_mem_ctrl #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  data_mem_if.slave bus
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW = IW + 2;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [1:0]     size_q, size_d;
  logic           uns_q, uns_d;
  logic           we_q, we_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           ready_q, ready_d;
  logic           busy_q, busy_d;
  logic           misal_q, misal_d;

  logic [31:0]    mem_q [DEPTH];
  logic [IW-1:0]  idx;
  logic [31:0]    mem_rd;
  logic [31:0]    mem_wd;
  logic           mem_we;
  logic           req;

  function automatic logic is_misal(
    input logic [1:0] sz,
    input logic [1:0] a
  );
    logic r;
    unique case (1'b1)
      sz == 2'b00: r = 1'b0;
      sz == 2'b01: r = a[0];
      default:     r = |a;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ld_ext(
    input logic [31:0] w,
    input logic [1:0]  sz,
    input logic [1:0]  a,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(w >> {a, 3'b000});
    h = a[1] ? w[31:16] : w[15:0];
    unique case (1'b1)
      sz == 2'b00: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      sz == 2'b01: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default:     r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] st_merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [1:0]  sz,
    input logic [1:0]  a
  );
    logic [31:0] r;
    r = old;
    unique case (1'b1)
      sz == 2'b00: r[{a, 3'b000} +: 8] = wd[7:0];
      sz == 2'b01: r[{a[1], 4'b0000} +: 16] = wd[15:0];
      default:     r = wd;
    endcase
    return r;
  endfunction

  // Upper address bits drop out here, so addresses alias modulo DEPTH words.
  assign idx    = addr_q[AW-1:2];
  assign mem_rd = mem_q[idx];
  assign mem_wd = st_merge(mem_rd, wdata_q, size_q, addr_q[1:0]);
  assign req    = bus.memread | bus.memwrite;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    busy_d  = busy_q;
    misal_d = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (is_misal(bus.size, bus.addr[1:0])) begin
            ready_d = 1'b1;
            misal_d = 1'b1;
          end else begin
            addr_d  = bus.addr[AW-1:0];
            size_d  = bus.size;
            uns_d   = bus.unsigned_ld;
            we_d    = bus.memwrite;
            wdata_d = bus.wdata;
            cnt_d   = CNT_INIT;
            busy_d  = 1'b1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          mem_we  = we_q;
          if (!we_q) begin
            rdata_d = ld_ext(mem_rd, size_q,
                             addr_q[1:0], uns_q);
          end
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      misal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      misal_q <= misal_d;
    end
  end

  // Array is never reset; a reset forces IDLE so a pending store is dropped.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx] <= mem_wd;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.misalign = misal_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: load/store widths, extension,
// misalign, busy-ignore, reset abort, address wrap, back-to-back.
module tb_data_mem_ctrl;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  data_mem_if bus();

  data_mem_ctrl #(
    .DEPTH   (256),
    .LATENCY (LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    bus.memread     = 1'b0;
    bus.memwrite    = 1'b0;
    bus.size        = 2'b00;
    bus.unsigned_ld = 1'b0;
    bus.addr        = '0;
    bus.wdata       = '0;
  endtask

  task automatic xfer(
    input string       tag,
    input logic        rd,
    input logic        wr,
    input logic [1:0]  sz,
    input logic        uns,
    input logic [31:0] a,
    input logic [31:0] wd,
    input int          exp_edges,
    input logic        poke,
    input logic        b2b
  );
    int   edges;
    logic bsy;
    if (!b2b) @(negedge clk);
    bus.memread     = rd;
    bus.memwrite    = wr;
    bus.size        = sz;
    bus.unsigned_ld = uns;
    bus.addr        = a;
    bus.wdata       = wd;
    @(posedge clk);
    @(negedge clk);
    idle_in();
    bsy   = bus.busy;
    edges = 0;
    while (!bus.ready && edges < 20) begin
      if (poke) begin
        bus.memread  = ~bus.memread;
        bus.memwrite = 1'b1;
        bus.addr     = 32'h20;
        bus.wdata    = 32'h0;
      end
      @(negedge clk);
      edges++;
    end
    idle_in();
    chk({tag, " ready"}, 32'(bus.ready), 32'd1);
    chk({tag, " lat"}, 32'(edges), 32'(exp_edges));
    chk({tag, " busy"}, 32'(bsy), 32'(exp_edges != 0));
    chk({tag, " misal"}, 32'(bus.misalign),
        32'(exp_edges == 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    idle_in();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst rdata", bus.rdata, 32'h0);
    chk("rst ready", 32'(bus.ready), 32'h0);
    chk("rst busy", 32'(bus.busy), 32'h0);
    chk("rst misal", 32'(bus.misalign), 32'h0);
    rst_n = 1'b1;

    // T1
    xfer("sw10", 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, LAT, 0, 0);
    chk("sw10 rdata", bus.rdata, 32'h0);
    xfer("lw10", 1, 0, 2'b10, 0, 32'h10, 32'h0, LAT, 0, 0);
    chk("lw10 rdata", bus.rdata, 32'hDEADBEEF);

    // T2
    xfer("lb13", 1, 0, 2'b00, 0, 32'h13, 32'h0, LAT, 0, 0);
    chk("lb13 rdata", bus.rdata, 32'hFFFFFFDE);
    xfer("lbu13", 1, 0, 2'b00, 1, 32'h13, 32'h0, LAT, 0, 0);
    chk("lbu13 rdata", bus.rdata, 32'h000000DE);
    xfer("lh10", 1, 0, 2'b01, 0, 32'h10, 32'h0, LAT, 0, 0);
    chk("lh10 rdata", bus.rdata, 32'hFFFFBEEF);
    xfer("lhu12", 1, 0, 2'b01, 1, 32'h12, 32'h0, LAT, 0, 0);
    chk("lhu12 rdata", bus.rdata, 32'h0000DEAD);
    xfer("lw11r", 1, 0, 2'b11, 0, 32'h10, 32'h0, LAT, 0, 0);
    chk("lw11r rdata", bus.rdata, 32'hDEADBEEF);

    // T3
    xfer("sb11", 0, 1, 2'b00, 0, 32'h11, 32'hFFFFFF55, LAT, 0, 0);
    xfer("lw10b", 1, 0, 2'b10, 0, 32'h10, 32'h0, LAT, 0, 0);
    chk("lw10b rdata", bus.rdata, 32'hDEAD55EF);
    xfer("sh12", 0, 1, 2'b01, 0, 32'h12, 32'hABCD1234, LAT, 0, 0);
    xfer("lw10c", 1, 0, 2'b10, 0, 32'h10, 32'h0, LAT, 0, 0);
    chk("lw10c rdata", bus.rdata, 32'h123455EF);

    // T4
    xfer("lw12m", 1, 0, 2'b10, 0, 32'h12, 32'h0, 0, 0, 0);
    chk("lw12m rdata", bus.rdata, 32'h123455EF);
    xfer("sh11m", 0, 1, 2'b01, 0, 32'h11, 32'h0000FFFF, 0, 0, 0);
    xfer("lw10d", 1, 0, 2'b10, 0, 32'h10, 32'h0, LAT, 0, 0);
    chk("lw10d rdata", bus.rdata, 32'h123455EF);

    // T5
    xfer("rw20", 1, 1, 2'b10, 0, 32'h20, 32'hA5A5A5A5, LAT, 0, 0);
    chk("rw20 rdata", bus.rdata, 32'h123455EF);
    xfer("lw20p", 1, 0, 2'b10, 0, 32'h20, 32'h0, LAT, 1, 0);
    chk("lw20p rdata", bus.rdata, 32'hA5A5A5A5);
    xfer("lw20", 1, 0, 2'b10, 0, 32'h20, 32'h0, LAT, 0, 0);
    chk("lw20 rdata", bus.rdata, 32'hA5A5A5A5);

    // T6
    xfer("sw30", 0, 1, 2'b10, 0, 32'h30, 32'h11111111, LAT, 0, 0);
    @(negedge clk);
    bus.memwrite = 1'b1;
    bus.size     = 2'b10;
    bus.addr     = 32'h30;
    bus.wdata    = 32'h22222222;
    @(posedge clk);
    @(negedge clk);
    idle_in();
    chk("abort busy0", 32'(bus.busy), 32'h1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort rdata", bus.rdata, 32'h0);
    chk("abort ready", 32'(bus.ready), 32'h0);
    chk("abort busy", 32'(bus.busy), 32'h0);
    chk("abort misal", 32'(bus.misalign), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    xfer("lw30", 1, 0, 2'b10, 0, 32'h30, 32'h0, LAT, 0, 0);
    chk("lw30 rdata", bus.rdata, 32'h11111111);

    // T7, load issued in the ready cycle of the store
    xfer("sw400", 0, 1, 2'b10, 0, 32'h400, 32'hCAFEF00D, LAT, 0, 0);
    xfer("lw000", 1, 0, 2'b10, 0, 32'h000, 32'h0, LAT, 0, 1);
    chk("lw000 rdata", bus.rdata, 32'hCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
